// File: rtl/uart_reg_pkg.sv
// uart_reg_pkg: command/response codes and FSM state encodings shared by the UART register bridge
package uart_reg_pkg;
  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_ACK = 8'h06;
  localparam logic [7:0] RSP_NAK = 8'h15;
  localparam logic [3:0] IDLE       = 4'd0;
  localparam logic [3:0] ADDR       = 4'd1;
  localparam logic [3:0] WDATA      = 4'd2;
  localparam logic [3:0] REG_WR     = 4'd3;
  localparam logic [3:0] REG_RD     = 4'd4;
  localparam logic [3:0] RD_WAIT    = 4'd5;
  localparam logic [3:0] TX_REQ     = 4'd6;
  localparam logic [3:0] TX_WAIT_HI = 4'd7;
  localparam logic [3:0] TX_WAIT_LO = 4'd8;
endpackage

// File: rtl/uart_tx_seq.sv
// uart_tx_seq: sends one byte through the UART transmitter handshake and pulses done when the frame ends
module uart_tx_seq
  import uart_reg_pkg::*;
(
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic       tx_status,
  output logic       tx_dvalid,
  output logic [7:0] tx_data,
  output logic       done
);
  logic [3:0] st;
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) begin
      st      <= IDLE;
      tx_data <= '0;
    end else begin
      unique case (st)
        IDLE: if (start) begin
          st      <= TX_REQ;
          tx_data <= tx_byte;
        end
        TX_REQ:     st <= TX_WAIT_HI;
        TX_WAIT_HI: if (tx_status) st <= TX_WAIT_LO;
        TX_WAIT_LO: if (!tx_status) st <= IDLE;
        default:    st <= IDLE;
      endcase
    end
  assign tx_dvalid = st == TX_REQ;
  assign done      = st == TX_WAIT_LO && !tx_status;
endmodule

// File: rtl/uart_reg_bridge.sv
// uart_reg_bridge: decodes host read/write commands from UART bytes, drives the register bus
// and returns ACK/NAK or read data through the UART transmitter.
module uart_reg_bridge
  import uart_reg_pkg::*;
#(
  parameter int ADDR_BYTES   = 2,
  parameter int BYTE_TIMEOUT = 4_000_000,
  parameter int RD_TIMEOUT   = 255
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic                    i_rx_dvalid,
  input  logic [7:0]              i_rx_data,
  output logic                    o_tx_dvalid,
  output logic [7:0]              o_tx_data,
  input  logic                    i_tx_status,
  output logic [8*ADDR_BYTES-1:0] o_reg_addr,
  output logic [31:0]             o_reg_wdata,
  output logic                    o_reg_wr,
  output logic                    o_reg_rd,
  input  logic [31:0]             i_reg_rdata,
  input  logic                    i_reg_rvalid
);
  localparam int AW = 8 * ADDR_BYTES;
  localparam int BW = $clog2(BYTE_TIMEOUT + 1);
  localparam int RW = $clog2(RD_TIMEOUT + 1);
  logic [3:0]    st;
  logic          is_wr;
  logic [7:0]    bcnt;
  logic [BW-1:0] tmo;
  logic [RW-1:0] rcnt;
  logic [31:0]   rbuf;
  logic [2:0]    cnt;
  logic          done;
  logic          tmo_hit;
  assign tmo_hit  = tmo == BW'(BYTE_TIMEOUT - 1);
  assign o_reg_wr = st == REG_WR;
  assign o_reg_rd = st == REG_RD;
  // rbuf always presents the next response byte in its top byte
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) begin
      st          <= IDLE;
      is_wr       <= 1'b0;
      bcnt        <= '0;
      tmo         <= '0;
      rcnt        <= '0;
      rbuf        <= '0;
      cnt         <= '0;
      o_reg_addr  <= '0;
      o_reg_wdata <= '0;
    end else begin
      unique case (st)
        IDLE: if (i_rx_dvalid) begin
          is_wr <= i_rx_data == CMD_WR;
          bcnt  <= '0;
          tmo   <= '0;
          if (i_rx_data == CMD_WR || i_rx_data == CMD_RD) st <= ADDR;
          else begin
            rbuf <= {RSP_NAK, 24'h0};
            cnt  <= 3'd1;
            st   <= TX_REQ;
          end
        end
        ADDR: if (i_rx_dvalid) begin
          o_reg_addr <= (o_reg_addr << 8) | AW'(i_rx_data);
          tmo        <= '0;
          bcnt       <= bcnt == 8'(ADDR_BYTES - 1) ? '0 : bcnt + 8'd1;
          if (bcnt == 8'(ADDR_BYTES - 1)) st <= is_wr ? WDATA : REG_RD;
        end else if (tmo_hit) st <= IDLE;
        else tmo <= tmo + BW'(1);
        WDATA: if (i_rx_dvalid) begin
          o_reg_wdata <= {o_reg_wdata[23:0], i_rx_data};
          tmo         <= '0;
          bcnt        <= bcnt + 8'd1;
          if (bcnt == 8'd3) st <= REG_WR;
        end else if (tmo_hit) st <= IDLE;
        else tmo <= tmo + BW'(1);
        REG_WR: begin
          rbuf <= {RSP_ACK, 24'h0};
          cnt  <= 3'd1;
          st   <= TX_REQ;
        end
        REG_RD: begin
          rcnt <= '0;
          st   <= RD_WAIT;
        end
        RD_WAIT: if (i_reg_rvalid) begin
          rbuf <= i_reg_rdata;
          cnt  <= 3'd4;
          st   <= TX_REQ;
        end else if (rcnt == RW'(RD_TIMEOUT - 1)) begin
          rbuf <= {RSP_NAK, 24'h0};
          cnt  <= 3'd1;
          st   <= TX_REQ;
        end else rcnt <= rcnt + RW'(1);
        TX_REQ: st <= TX_WAIT_LO;
        TX_WAIT_LO: if (done) begin
          rbuf <= rbuf << 8;
          cnt  <= cnt - 3'd1;
          st   <= cnt == 3'd1 ? IDLE : TX_REQ;
        end
        default: st <= IDLE;
      endcase
    end
  uart_tx_seq u_tx_seq (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .start    (st == TX_REQ),
    .tx_byte  (rbuf[31:24]),
    .tx_status(i_tx_status),
    .tx_dvalid(o_tx_dvalid),
    .tx_data  (o_tx_data),
    .done     (done)
  );
endmodule
